// File: rtl/mem_loader_pkg.sv
// rtl/mem_loader_pkg.sv - shared types and constants for the byte-stream memory loader
// Contents: BYTE_WIDTH constant and the loader FSM state enum.
// Build option: MEM_LOADER_VERIFY_EN adds the VERIFY (write readback) state.
package mem_loader_pkg;

    localparam int BYTE_WIDTH = 8;

`ifdef MEM_LOADER_VERIFY_EN
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_VERIFY  = 3'd3,
        ST_DONE    = 3'd4
    } state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_DONE    = 3'd4
    } state_e;
`endif

endpackage

// File: rtl/mem_loader_byte_packer.sv
// rtl/mem_loader_byte_packer.sv - little-endian byte-to-word assembly for mem_loader
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear_i      restart assembly at byte 0 with an empty word
//   load_i       store byte_i into the current byte lane and advance the lane index
//   byte_i       incoming byte
//   word_o       assembly register (byte k in bits [8k+7:8k])
//   last_o       the next load completes the word
module byte_packer
    import mem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic [BYTE_WIDTH-1:0] byte_i,
    output logic [DATA_WIDTH-1:0] word_o,
    output logic                  last_o
);

    localparam int BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;

    assign last_o = (idx_q == LAST_IDX);
    assign word_o = word_q;

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clear_i) begin
            idx_d  = '0;
            word_d = '0;
        end else if (load_i) begin
            for (int k = 0; k < BYTES; k++) begin
                if (idx_q == IDX_W'(k)) begin
                    word_d[k*BYTE_WIDTH +: BYTE_WIDTH] = byte_i;
                end
            end
            idx_d = last_o ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - byte-stream to SRAM word loader (top)
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, base_addr, word_count  load request (sampled in IDLE only)
//   byte_in, byte_valid, byte_ready  byte stream handshake
//   mem_addr, mem_din, mem_wr_en    SRAM write port
//   mem_dout                    SRAM read data (MEM_LOADER_VERIFY_EN only)
//   busy, done                  status; done is a one-cycle pulse
//   verify_err                  sticky readback mismatch (MEM_LOADER_VERIFY_EN only)
// Build option: MEM_LOADER_VERIFY_EN enables a readback compare after each write.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MEM_DEPTH  = 65536,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic [BYTE_WIDTH-1:0] byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_wr_en,
`ifdef MEM_LOADER_VERIFY_EN
    input  logic [DATA_WIDTH-1:0] mem_dout,
`endif
    output logic                  busy,
    output logic                  done
`ifdef MEM_LOADER_VERIFY_EN
    ,
    output logic                  verify_err
`endif
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   ONE_WORD  = (ADDR_WIDTH + 1)'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;

    logic                  pack_clear;
    logic                  pack_load;
    logic                  pack_last;
    logic [DATA_WIDTH-1:0] pack_word;
    logic                  advance;

`ifdef MEM_LOADER_VERIFY_EN
    logic verify_err_q, verify_err_d;
`endif

    byte_packer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_packer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear_i(pack_clear),
        .load_i (pack_load),
        .byte_i (byte_in),
        .word_o (pack_word),
        .last_o (pack_last)
    );

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        pack_clear  = 1'b0;
        pack_load   = 1'b0;
        advance     = 1'b0;
`ifdef MEM_LOADER_VERIFY_EN
        verify_err_d = verify_err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
`ifdef MEM_LOADER_VERIFY_EN
                    verify_err_d = 1'b0;
`endif
                    if (word_count == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        cur_addr_d  = base_addr;
                        remaining_d = word_count;
                        pack_clear  = 1'b1;
                        state_d     = ST_COLLECT;
                    end
                end
            end
            ST_COLLECT: begin
                // byte_ready is 1 throughout COLLECT, so valid alone completes a transfer
                if (byte_valid) begin
                    pack_load = 1'b1;
                    if (pack_last) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
`ifdef MEM_LOADER_VERIFY_EN
                state_d = ST_VERIFY;
`else
                advance = 1'b1;
`endif
            end
`ifdef MEM_LOADER_VERIFY_EN
            ST_VERIFY: begin
                // combinational SRAM read of the address just written
                if (mem_dout != pack_word) begin
                    verify_err_d = 1'b1;
                end
                advance = 1'b1;
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // word finished: either stop or move to the next address
        if (advance) begin
            if (remaining_q == ONE_WORD) begin
                state_d = ST_DONE;
            end else begin
                state_d     = ST_COLLECT;
                remaining_d = remaining_q - ONE_WORD;
                cur_addr_d  = (cur_addr_q == LAST_ADDR) ? '0 : cur_addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
`ifdef MEM_LOADER_VERIFY_EN
            verify_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
`ifdef MEM_LOADER_VERIFY_EN
            verify_err_q <= verify_err_d;
`endif
        end
    end

    assign byte_ready = (state_q == ST_COLLECT);
    assign mem_wr_en  = (state_q == ST_WRITE);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign mem_addr   = cur_addr_q;
    assign mem_din    = pack_word;
`ifdef MEM_LOADER_VERIFY_EN
    assign verify_err = verify_err_q;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - self-checking bench for mem_loader with SRAM model and write scoreboard
module tb_mem_loader;

    localparam int DW = 16;
    localparam int AW = 16;
`ifdef MEM_LOADER_VERIFY_EN
    localparam int PW = 4;
`else
    localparam int PW = 3;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   word_count;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_wr_en;
    logic          busy;
    logic          done;
`ifdef MEM_LOADER_VERIFY_EN
    logic [DW-1:0] mem_dout;
    logic          verify_err;
`endif

    logic [DW-1:0] mem [0:65535];
    logic [31:0]   exp_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int ready_cnt = 0;

    mem_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .word_count(word_count),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_wr_en (mem_wr_en),
`ifdef MEM_LOADER_VERIFY_EN
        .mem_dout  (mem_dout),
`endif
        .busy      (busy),
        .done      (done)
`ifdef MEM_LOADER_VERIFY_EN
        ,
        .verify_err(verify_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (mem_wr_en) mem[mem_addr] <= mem_din;
    end

`ifdef MEM_LOADER_VERIFY_EN
    // address 0x20 has bit 0 stuck at 1 on readback
    assign mem_dout = mem[mem_addr] | ((mem_addr == 16'h0020) ? 16'h0001 : 16'h0000);
`endif

    // scoreboard: every write must match the next expected {addr, data}
    always @(negedge clk) begin
        logic [31:0] e;
        if (mem_wr_en) begin
            wr_cnt++;
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_write: observed addr %0h data %0h expected no write", mem_addr, mem_din);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                tests++;
                assert ({mem_addr, mem_din} === e) else begin
                    fails++;
                    $error("FAIL write_sb: observed %0h expected %0h", {mem_addr, mem_din}, e);
                end
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (byte_ready) ready_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [AW-1:0] base, input logic [AW:0] cnt);
        base_addr  = base;
        word_count = cnt;
        start      = 1'b1;
        @(negedge clk);
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit took;
        byte_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        byte_in    = b;
        byte_valid = 1'b1;
        took       = 1'b0;
        for (int i = 0; i < 50 && !took; i++) begin
            @(negedge clk);
            took = byte_ready;
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b0;
        tests++;
        assert (took) else begin
            fails++;
            $error("FAIL byte_accept: observed no transfer expected transfer of %0h", b);
        end
    endtask

    task automatic send_word(input logic [AW-1:0] addr, input logic [DW-1:0] w, input int maxgap);
        exp_q.push_back({addr, w});
        send_byte(w[7:0], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        send_byte(w[15:8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 300 && done_cnt < target; i++) begin
            @(posedge clk);
            #1;
        end
        check("done_seen", done_cnt, target);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int d0;
        int w0;
        int r0;
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        rst_n      = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        byte_in    = '0;
        byte_valid = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_byte_ready", byte_ready, 0);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_din", mem_din, 0);
`ifdef MEM_LOADER_VERIFY_EN
        check("rst_verify_err", verify_err, 0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // basic two-word load, no stalls
        d0 = done_cnt; w0 = wr_cnt;
        do_start(16'h0010, 2);
        check("t1_busy", busy, 1);
        check("t1_ready", byte_ready, 1);
        send_word(16'h0010, 16'h1234, 0);
        send_word(16'h0011, 16'h5678, 0);
        wait_done(d0 + 1);
        check("t1_latency", done_cyc - start_cyc, 1 + 2 * PW);
        check("t1_wr_cycles", wr_cnt - w0, 2);
        check("t1_done_pulses", done_cnt - d0, 1);
        check("t1_mem10", mem[16'h0010], 16'h1234);
        check("t1_mem11", mem[16'h0011], 16'h5678);
        check("t1_idle", busy, 0);
`ifdef MEM_LOADER_VERIFY_EN
        check("t1_no_verr", verify_err, 0);
`endif

        // address wrap at the top of memory
        d0 = done_cnt; w0 = wr_cnt;
        do_start(16'hFFFF, 2);
        send_word(16'hFFFF, 16'hBBAA, 0);
        send_word(16'h0000, 16'hDDCC, 0);
        wait_done(d0 + 1);
        check("t2_wr_cycles", wr_cnt - w0, 2);
        check("t2_memFFFF", mem[16'hFFFF], 16'hBBAA);
        check("t2_mem0000", mem[16'h0000], 16'hDDCC);

        // zero count
        d0 = done_cnt; w0 = wr_cnt; r0 = ready_cnt;
        do_start(16'h0100, 0);
        check("t3_done_now", done, 1);
        wait_done(d0 + 1);
        check("t3_latency", done_cyc - start_cyc, 1);
        check("t3_no_ready", ready_cnt - r0, 0);
        check("t3_no_write", wr_cnt - w0, 0);

        // random stalls plus an ignored start while busy
        d0 = done_cnt; w0 = wr_cnt;
        do_start(16'h0040, 2);
        exp_q.push_back({16'h0040, 16'h1234});
        send_byte(8'h34, int'($urandom_range(0, 5)));
        base_addr  = 16'h0080;
        word_count = 1;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_byte(8'h12, int'($urandom_range(0, 5)));
        send_word(16'h0041, 16'h5678, 5);
        wait_done(d0 + 1);
        check("t4_mem40", mem[16'h0040], 16'h1234);
        check("t4_mem41", mem[16'h0041], 16'h5678);
        check("t4_mem80", mem[16'h0080], 16'h0000);
        check("t4_wr_cycles", wr_cnt - w0, 2);
        check("t4_done_pulses", done_cnt - d0, 1);

        // reset in the middle of word 1
        d0 = done_cnt; w0 = wr_cnt;
        do_start(16'h0060, 3);
        send_byte(8'h11, 0);
        rst_n = 1'b0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_ready", byte_ready, 0);
        check("t5_addr", mem_addr, 0);
        check("t5_din", mem_din, 0);
        check("t5_wr_en", mem_wr_en, 0);
        check("t5_done", done, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("t5_no_write", wr_cnt - w0, 0);
        check("t5_no_done", done_cnt - d0, 0);
        check("t5_mem60", mem[16'h0060], 16'h0000);
        do_start(16'h0060, 3);
        send_word(16'h0060, 16'hA1B2, 1);
        send_word(16'h0061, 16'hC3D4, 1);
        send_word(16'h0062, 16'hE5F6, 1);
        wait_done(d0 + 1);
        check("t5_mem60b", mem[16'h0060], 16'hA1B2);
        check("t5_mem61", mem[16'h0061], 16'hC3D4);
        check("t5_mem62", mem[16'h0062], 16'hE5F6);
        check("t5_wr_cycles", wr_cnt - w0, 3);

`ifdef MEM_LOADER_VERIFY_EN
        // readback mismatch on the faulty address
        d0 = done_cnt;
        do_start(16'h0020, 1);
        send_word(16'h0020, 16'h1234, 0);
        wait_done(d0 + 1);
        check("t6_verr_set", verify_err, 1);
        check("t6_done_pulses", done_cnt - d0, 1);
        do_start(16'h0000, 0);
        check("t6_verr_clr", verify_err, 0);
        wait_done(d0 + 2);
`endif

        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
